// File: rtl/demux_pkg.sv
// ============================================================================
// Module   : demux_pkg
// Brief    : Shared widths and lane type for the demux bank.
// Revision : 1.0
// ============================================================================
`default_nettype none

package demux_pkg;

    localparam int W124_DEF = 4;
    localparam int SEL181_W = 3;

    typedef logic [W124_DEF-1:0] lane124_t;

endpackage

`default_nettype wire

// File: rtl/demux_core.sv
// ============================================================================
// Module   : demux_core
// Brief    : One registered 1-to-N demux of DW-bit lanes. With DEMUX_HOLD_EN
//            defined, unselected lanes keep their value instead of clearing.
// Revision : 1.0
// ============================================================================
`default_nettype none

module demux_core #(
    parameter int DW = 1,
    parameter int N  = 2,
    parameter int SW = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [DW-1:0]   in_data,
    input  logic [SW-1:0]   in_sel,
    output logic [N*DW-1:0] out_data
);

    logic [N*DW-1:0] r_lanes;
    logic [N*DW-1:0] w_next;

    always_comb begin
`ifdef DEMUX_HOLD_EN
        w_next = r_lanes;
`else
        w_next = '0;
`endif
        for (int k = 0; k < N; k++) begin
            if (in_sel == SW'(k)) begin
                w_next[k*DW +: DW] = in_data;
            end
        end
    end

    // Reset overrides data and select on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_lanes <= '0;
        end else begin
            r_lanes <= w_next;
        end
    end

    assign out_data = r_lanes;

endmodule

`default_nettype wire

// File: rtl/demux_bank.sv
// ============================================================================
// Module   : demux_bank
// Brief    : Three independent registered demuxes (1:2 bit, 1:2 nibble,
//            1:8 bit). Optional feature macro: DEMUX_HOLD_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module demux_bank
    import demux_pkg::*;
#(
    parameter int W124 = W124_DEF,
    parameter int N181 = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_data_121,
    input  logic                in_sel_121,
    output logic [1:0]          out_data_121,
    input  logic [W124-1:0]     in_data_124,
    input  logic                in_sel_124,
    output logic [2*W124-1:0]   out_data_124,
    input  logic                in_data_181,
    input  logic [SEL181_W-1:0] in_sel_181,
    output logic [N181-1:0]     out_data_181
);

    demux_core #(.DW(1), .N(2), .SW(1)) u_demux_121 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data_121),
        .in_sel   (in_sel_121),
        .out_data (out_data_121)
    );

    demux_core #(.DW(W124), .N(2), .SW(1)) u_demux_124 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data_124),
        .in_sel   (in_sel_124),
        .out_data (out_data_124)
    );

    demux_core #(.DW(1), .N(N181), .SW(SEL181_W)) u_demux_181 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data_181),
        .in_sel   (in_sel_181),
        .out_data (out_data_181)
    );

endmodule

`default_nettype wire

// File: tb/tb_demux_bank.sv
// ============================================================================
// Module   : tb_demux_bank
// Brief    : Self-checking bench for demux_bank: directed plan plus random
//            traffic against a lane-array reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_demux_bank;

    logic       clk;
    logic       rst_n;
    logic       in_data_121;
    logic       in_sel_121;
    logic [1:0] out_data_121;
    logic [3:0] in_data_124;
    logic       in_sel_124;
    logic [7:0] out_data_124;
    logic       in_data_181;
    logic [2:0] in_sel_181;
    logic [7:0] out_data_181;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference lanes, indexed by lane number.
    logic       m121 [2];
    logic [3:0] m124 [2];
    logic       m181 [8];

    demux_bank dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_data_121  (in_data_121),
        .in_sel_121   (in_sel_121),
        .out_data_121 (out_data_121),
        .in_data_124  (in_data_124),
        .in_sel_124   (in_sel_124),
        .out_data_124 (out_data_124),
        .in_data_181  (in_data_181),
        .in_sel_181   (in_sel_181),
        .out_data_181 (out_data_181)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] pack121();
        return {m121[1], m121[0]};
    endfunction

    function automatic logic [7:0] pack124();
        return {m124[1], m124[0]};
    endfunction

    function automatic logic [7:0] pack181();
        logic [7:0] v;
        for (int k = 0; k < 8; k++) v[k] = m181[k];
        return v;
    endfunction

    task automatic compare_all(input string tag);
        check({tag, "_121"}, 32'(out_data_121), 32'(pack121()));
        check({tag, "_124"}, 32'(out_data_124), 32'(pack124()));
        check({tag, "_181"}, 32'(out_data_181), 32'(pack181()));
    endtask

    // One clock: drive inputs, confirm outputs did not move before the edge,
    // then update the model and compare after the edge.
    task automatic step(input logic d121, input logic s121,
                        input logic [3:0] d124, input logic s124,
                        input logic d181, input logic [2:0] s181,
                        input logic rn);
        in_data_121 = d121;
        in_sel_121  = s121;
        in_data_124 = d124;
        in_sel_124  = s124;
        in_data_181 = d181;
        in_sel_181  = s181;
        rst_n       = rn;
        #1;
        compare_all("hold_pre_edge");
        @(posedge clk);
        #1;
        if (!rn) begin
            foreach (m121[k]) m121[k] = 1'b0;
            foreach (m124[k]) m124[k] = 4'h0;
            foreach (m181[k]) m181[k] = 1'b0;
        end else begin
`ifndef DEMUX_HOLD_EN
            foreach (m121[k]) m121[k] = 1'b0;
            foreach (m124[k]) m124[k] = 4'h0;
            foreach (m181[k]) m181[k] = 1'b0;
`endif
            m121[int'(s121)] = d121;
            m124[int'(s124)] = d124;
            m181[int'(s181)] = d181;
        end
        compare_all("post_edge");
    endtask

    initial begin
        foreach (m121[k]) m121[k] = 1'b0;
        foreach (m124[k]) m124[k] = 4'h0;
        foreach (m181[k]) m181[k] = 1'b0;
        rst_n = 1'b0;
        in_data_121 = 1'b0; in_sel_121 = 1'b0;
        in_data_124 = 4'h0; in_sel_124 = 1'b0;
        in_data_181 = 1'b0; in_sel_181 = 3'd0;
        @(posedge clk);
        #1;

        // Reset held with live data on the inputs.
        step(1'b1, 1'b1, 4'hF, 1'b1, 1'b1, 3'd5, 1'b0);
        step(1'b1, 1'b1, 4'hF, 1'b1, 1'b1, 3'd5, 1'b0);
        check("reset_121", 32'(out_data_121), 32'h0);
        check("reset_124", 32'(out_data_124), 32'h0);
        check("reset_181", 32'(out_data_181), 32'h0);
        step(1'b0, 1'b0, 4'hF, 1'b1, 1'b0, 3'd0, 1'b1);
        check("release_124", 32'(out_data_124), 32'hF0);

        // 1-to-8 sweep with data 1, then data 0.
        for (int s = 0; s < 8; s++) begin
            step(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 3'(s), 1'b1);
`ifndef DEMUX_HOLD_EN
            check("sweep181_one", 32'(out_data_181), 32'h1 << s);
`endif
        end
        for (int s = 0; s < 8; s++) begin
            step(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 3'(s), 1'b1);
            check("sweep181_lane_zero", 32'(out_data_181[s]), 32'h0);
        end

        // 1-to-2 bit.
        step(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 3'd0, 1'b1);
        check("d121_sel0", 32'(out_data_121), 32'h1);
        step(1'b1, 1'b1, 4'h0, 1'b0, 1'b0, 3'd0, 1'b1);
`ifndef DEMUX_HOLD_EN
        check("d121_sel1", 32'(out_data_121), 32'h2);
`endif
        step(1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 3'd0, 1'b1);
        step(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 3'd0, 1'b1);
        check("d121_zero", 32'(out_data_121), 32'h0);

        // Nibble sweep, both lanes.
        for (int d = 0; d < 16; d++) begin
            step(1'b0, 1'b0, 4'(d), 1'b0, 1'b0, 3'd0, 1'b1);
            check("sweep124_lo", 32'(out_data_124[3:0]), 32'(d));
        end
        for (int d = 0; d < 16; d++) begin
            step(1'b0, 1'b0, 4'(d), 1'b1, 1'b0, 3'd0, 1'b1);
            check("sweep124_hi", 32'(out_data_124[7:4]), 32'(d));
        end

        // Hold-mode distinguishing sequence.
        step(1'b0, 1'b0, 4'h5, 1'b0, 1'b0, 3'd0, 1'b1);
        step(1'b0, 1'b0, 4'hA, 1'b1, 1'b0, 3'd0, 1'b1);
`ifdef DEMUX_HOLD_EN
        check("hold_seq", 32'(out_data_124), 32'hA5);
`else
        check("hold_seq", 32'(out_data_124), 32'hA0);
`endif

        // All selects change together on one edge.
        step(1'b1, 1'b0, 4'h3, 1'b0, 1'b1, 3'd2, 1'b1);
        step(1'b1, 1'b1, 4'hC, 1'b1, 1'b1, 3'd6, 1'b1);

        // Random traffic with occasional mid-stream reset.
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom), 1'($urandom), 4'($urandom), 1'($urandom),
                 1'($urandom), 3'($urandom), ($urandom_range(0, 19) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/demux_bank.md
# demux_bank

Bank of three independent registered one-to-N demultiplexers sharing one clock and reset: a 1-to-2 bit demux, a 1-to-2 nibble demux (4-bit lanes), and a 1-to-8 bit demux. Each routes its input data to the lane chosen by its select and drives every other lane to zero. The block sits in the datapath wherever a serial bit or nibble stream must be steered to one of several consumers, e.g. per-chip or per-symbol fan-out.

## Interface
- Parameters:
- `W124`, default 4: lane width of the nibble demux.
- `N181`, default 8: lane count of the 1-to-8 demux, fixed at 8; select width is log2(N181) = 3.
- Ports:
- `clk` in, 1: sole clock, rising-edge.
- `rst_n` in, 1: reset, synchronous, active-low, sampled on `clk` rising edge.
- `in_data_121` in, 1: data for the 1-to-2 demux.
- `in_sel_121` in, 1: lane select for the 1-to-2 demux.
- `out_data_121` out, 2: lanes of the 1-to-2 demux.
- `in_data_124` in, W124: data for the nibble demux.
- `in_sel_124` in, 1: lane select for the nibble demux.
- `out_data_124` out, 2*W124: lane 0 = [W124-1:0], lane 1 = [2*W124-1:W124].
- `in_data_181` in, 1: data for the 1-to-8 demux.
- `in_sel_181` in, 3: lane select for the 1-to-8 demux.
- `out_data_181` out, 8: lanes; bit k = lane k.

## Operation
- Each demux is independent; no interaction between channels.
- out_data_121[s] = in_data_121 where s = in_sel_121; the other bit is 0.
- out_data_124 lane s = in_data_124 where s = in_sel_124; the other lane is 0.
- out_data_181[s] = in_data_181 where s = in_sel_181; all seven other bits are 0.
- Every select value is legal; no invalid codes exist.
- Data value 0 on the selected lane yields an all-zero output.
- Unknown or X select inputs are not supported; outputs are then undefined.

## Timing
- All outputs are registered with 1 cycle of latency: inputs sampled at edge n appear on the outputs after edge n.
- No combinational path from inputs to outputs.
- While rst_n = 0 at a rising edge, all outputs clear to 0 on that edge, overriding any data and select values.
- The first post-reset edge with rst_n = 1 loads normally.
- Reset mid-stream discards in-flight values; there is no recovery state.
- A change in select and data on the same edge is captured together; there is no glitch lane.

## Configuration
- Macro `DEMUX_HOLD_EN`.
- Undefined (default): unselected lanes are driven to 0 every cycle, as described in Operation.
- Defined: unselected lanes hold their last registered value, and only the selected lane updates. Reset still clears all lanes to 0.

## Structure
- Shared package `demux_pkg`, containing:
- `W124_DEF = 4`
- `SEL181_W = 3`
- typedef `lane124_t` (logic [W124-1:0])
- One sub-module, `demux_core`, parameterized by data width DW and lane count N. It implements one registered demux, including the `DEMUX_HOLD_EN` behaviour.
- `demux_bank` instantiates `demux_core` three times: (DW=1, N=2), (DW=W124, N=2), (DW=1, N=8).

## Test plan
- Reset: hold rst_n = 0 for 2 cycles with in_data_124 = 4'hF, in_sel_124 = 1, in_data_181 = 1 -> all outputs read 0; on the first edge after release, out_data_124 = 8'hF0.
- 1-to-8 sweep: in_data_181 = 1, in_sel_181 = 0..7 -> one cycle later out_data_181 = 8'h01, 02, 04, …, 80; with in_data_181 = 0 -> 8'h00 for every select.
- 1-to-2: in_data_121 = 1 with in_sel_121 = 0 then 1 -> 2'b01 then 2'b10; in_data_121 = 0 -> 2'b00.
- Nibble sweep: in_data_124 = 0..F at in_sel_124 = 0 -> out_data_124 = 8'h00..8'h0F; at in_sel_124 = 1 -> 8'h00..8'hF0, stepping 8'h10.
- Latency and independence: change all three selects on one edge -> each output updates exactly one cycle later with no cross-channel effect.
- With `DEMUX_HOLD_EN`:
- in_sel_124 = 0, in_data_124 = 4'h5, then in_sel_124 = 1, in_data_124 = 4'hA -> out_data_124 = 8'hA5.
- Without `DEMUX_HOLD_EN`, the same sequence gives 8'hA0.
